pipe_hazard_unit: RTL and testbench
===================================

# pipe_hazard_unit

Hazard and forwarding controller for the 5-stage pipeline. It sits beside the decode→execute pipeline register and consumes that register's execute-side outputs (destination address, source addresses, control). It keeps its own registered view of the memory and writeback stages, and from it drives the forwarded execute operands and the stall and flush controls for every stage. An optional multi-cycle multiply stall sequencer is included.

## Interface
- bits, 32, datapath width of the operands and forwarded values
- MUL_LATENCY, 3, execute-stage cycles a multiply occupies (≥2; only used with the multiply stall enabled)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- RA1D, RA2D  in  4  decode-stage source register addresses
- RA1E, RA2E  in  4  execute-stage source register addresses
- WA3E  in  4  execute-stage destination address
- RegWriteE  in  1  execute instruction writes the register file
- MemToRegE  in  1  execute instruction is a load
- BranchTakenE  in  1  branch resolved taken in execute
- MulStartE  in  1  execute instruction is a multiply (first cycle)
- RD1E, RD2E  in  bits  register-file operands from the execute register
- ALUResultM  in  bits  memory-stage ALU result
- ResultW  in  bits  writeback-stage result
- SrcAE, SrcBE  out  bits  forwarded execute operands
- ForwardAE, ForwardBE  out  2  00 = register file, 10 = M stage, 01 = W stage
- StallF, StallD, StallE  out  1  hold the fetch, decode and execute registers
- FlushD, FlushE  out  1  clear the decode and execute registers next edge

## Operation
- Tracking registers:
  - WA3M and RegWriteM, loaded from WA3E and RegWriteE every edge.
  - WA3W and RegWriteW, loaded from the M-stage tracking registers.
  - When StallE=1, a bubble is loaded into the M stage: RegWriteM=0.
- Forwarding of operand A (B identical, using RA2E, RD2E and SrcBE):
  - 10 if RegWriteM and WA3M==RA1E and RA1E≠4'hF.
  - Else 01 if RegWriteW and WA3W==RA1E and RA1E≠4'hF.
  - Else 00.
  - M-stage forwarding has priority over W-stage. R15 is never forwarded.
- SrcAE and SrcBE are muxed from RD1E/RD2E, ALUResultM or ResultW per the forward code. Code 11 cannot occur; if it does, the register-file value is selected.
- Load-use hazard (ldrstall): MemToRegE & RegWriteE & (WA3E==RA1D | WA3E==RA2D).
  - Asserts StallF, StallD and FlushE for one cycle.
- Branch: BranchTakenE asserts FlushD and FlushE. BranchTakenE=1 suppresses ldrstall, because the stalled decode instruction is being discarded anyway.
- Combined outputs:
  - StallF = StallD = ldrstall | mulbusy
  - StallE = mulbusy
  - FlushE = (ldrstall | BranchTakenE) & ~mulbusy
  - FlushD = BranchTakenE & ~mulbusy
- Multiply sequencer (states IDLE and MUL_BUSY; counter of width clog2(MUL_LATENCY)):
  - IDLE & MulStartE → MUL_BUSY, counter loaded with MUL_LATENCY-2.
  - In MUL_BUSY, the counter decrements each cycle. At counter 0 → IDLE.
  - mulbusy = (state==MUL_BUSY) | (state==IDLE & MulStartE).
  - MulStartE is ignored while in MUL_BUSY.
  - BranchTakenE is ignored while mulbusy=1. The multiply occupies execute, so no branch can resolve there.
  - Total execute occupancy is exactly MUL_LATENCY cycles.

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs and the tracking/state registers. They are zero-latency within the cycle.
- Tracking registers and the sequencer update on the rising clk edge.
- Reset (rst=0, async) sets:
  - All tracking registers to 0 and RegWriteM=RegWriteW=0.
  - state=IDLE and counter=0.
  - With inputs quiescent, outputs are then ForwardAE=ForwardBE=00, SrcAE=RD1E, SrcBE=RD2E, and all stall and flush outputs 0.
- A reset during MUL_BUSY returns to IDLE immediately; the stall drops asynchronously.
- A load-use stall lasts exactly one cycle. The dependent instruction re-evaluates with the load in M and then forwards 01 from W.

## Configuration
- HAZARD_MUL_STALL_EN defined: the multiply sequencer and StallE behave as above.
- HAZARD_MUL_STALL_EN undefined:
  - No sequencer or counter is built.
  - mulbusy is tied to 0, so StallE=0 and MulStartE is unused.
  - MUL_LATENCY is ignored.

## Test plan
- Reset: rst=0 mid-run → all stalls and flushes 0, ForwardAE=ForwardBE=00, SrcAE==RD1E.
- M forward: cycle n has WA3E=3, RegWriteE=1; cycle n+1 has RA1E=3 and ALUResultM=32'h1234 → ForwardAE=10, SrcAE=32'h1234.
- Priority and R15:
  - W and M both target register 5 with RA2E=5 → ForwardBE=10.
  - Any tracked write to register 15 with RA1E=15 → ForwardAE=00.
- Load-use: MemToRegE=1, RegWriteE=1, WA3E=2, RA2D=2 → StallF=StallD=FlushE=1 for exactly one cycle. Adding BranchTakenE=1 in the same cycle gives StallD=0 and FlushD=FlushE=1.
- Multiply (macro on, MUL_LATENCY=3): MulStartE pulse → StallF=StallD=StallE=1 for 3 cycles, RegWriteM=0 during the stall, then IDLE. A second MulStartE while busy is ignored. With the macro off, StallE stays 0.
- Reset mid-multiply: rst=0 during the second busy cycle → stalls drop immediately and state is IDLE after release.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller: M/W tracking, operand forwarding, load-use and branch control.
// Optional multi-cycle multiply stall sequencer enabled by defining HAZARD_MUL_STALL_EN.
module pipe_hazard_unit #(
    parameter int bits        = 32,
    parameter int MUL_LATENCY = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      RA1D,
    input  logic [3:0]      RA2D,
    input  logic [3:0]      RA1E,
    input  logic [3:0]      RA2E,
    input  logic [3:0]      WA3E,
    input  logic            RegWriteE,
    input  logic            MemToRegE,
    input  logic            BranchTakenE,
    input  logic            MulStartE,
    input  logic [bits-1:0] RD1E,
    input  logic [bits-1:0] RD2E,
    input  logic [bits-1:0] ALUResultM,
    input  logic [bits-1:0] ResultW,
    output logic [bits-1:0] SrcAE,
    output logic [bits-1:0] SrcBE,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE,
    output logic            StallF,
    output logic            StallD,
    output logic            StallE,
    output logic            FlushD,
    output logic            FlushE
);

    logic [3:0] wa3m_reg;
    logic [3:0] wa3w_reg;
    logic       regwritem_reg;
    logic       regwritew_reg;
    logic       mulbusy;
    logic       branch_eff;
    logic       ldrstall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wa3m_reg      <= 4'h0;
            wa3w_reg      <= 4'h0;
            regwritem_reg <= 1'b0;
            regwritew_reg <= 1'b0;
        end else begin
            wa3m_reg      <= WA3E;
            regwritem_reg <= RegWriteE & ~StallE;
            wa3w_reg      <= wa3m_reg;
            regwritew_reg <= regwritem_reg;
        end
    end

    // Operand 0 is A, operand 1 is B; identical forwarding logic for both.
    logic [3:0]      ra_e  [2];
    logic [bits-1:0] rd_e  [2];
    logic [bits-1:0] src_e [2];
    logic [1:0]      fwd   [2];

    assign ra_e[0] = RA1E;
    assign ra_e[1] = RA2E;
    assign rd_e[0] = RD1E;
    assign rd_e[1] = RD2E;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd[gi] = (regwritem_reg && (wa3m_reg == ra_e[gi]) && (ra_e[gi] != 4'hF)) ? 2'b10 :
                             (regwritew_reg && (wa3w_reg == ra_e[gi]) && (ra_e[gi] != 4'hF)) ? 2'b01 :
                             2'b00;
            assign src_e[gi] = (fwd[gi] == 2'b10) ? ALUResultM :
                               (fwd[gi] == 2'b01) ? ResultW    :
                               rd_e[gi];
        end
    endgenerate

    assign ForwardAE = fwd[0];
    assign ForwardBE = fwd[1];
    assign SrcAE     = src_e[0];
    assign SrcBE     = src_e[1];

`ifdef HAZARD_MUL_STALL_EN
    localparam int CW = $clog2(MUL_LATENCY);

    typedef enum logic {IDLE, MUL_BUSY} state_t;
    state_t        state_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (MulStartE) begin
                        state_reg <= MUL_BUSY;
                        cnt_reg   <= CW'(MUL_LATENCY - 2);
                    end
                end
                MUL_BUSY: begin
                    if (cnt_reg == '0) state_reg <= IDLE;
                    else               cnt_reg   <= cnt_reg - CW'(1);
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // The start cycle already counts as busy, so occupancy totals MUL_LATENCY.
    assign mulbusy = (state_reg == MUL_BUSY) | ((state_reg == IDLE) & MulStartE);
`else
    localparam int unused_mul_latency = MUL_LATENCY;
    logic unused_mul_start;
    assign unused_mul_start = MulStartE;
    assign mulbusy          = 1'b0;
`endif

    // A taken branch discards the decode instruction, so it cancels a load-use stall.
    assign branch_eff = BranchTakenE & ~mulbusy;
    assign ldrstall   = MemToRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D)) & ~branch_eff;

    assign StallF = ldrstall | mulbusy;
    assign StallD = ldrstall | mulbusy;
    assign StallE = mulbusy;
    assign FlushE = (ldrstall | BranchTakenE) & ~mulbusy;
    assign FlushD = branch_eff;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: forwarding, priority, R15, load-use, branch, multiply, reset.
module tb_pipe_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E;
    logic        RegWriteE, MemToRegE, BranchTakenE, MulStartE;
    logic [31:0] RD1E, RD2E, ALUResultM, ResultW;
    logic [31:0] SrcAE, SrcBE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, FlushD, FlushE;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit #(.bits(32), .MUL_LATENCY(3)) dut (
        .clk(clk), .rst(rst),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
        .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .BranchTakenE(BranchTakenE),
        .MulStartE(MulStartE),
        .RD1E(RD1E), .RD2E(RD2E), .ALUResultM(ALUResultM), .ResultW(ResultW),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Packs {StallF,StallD,StallE,FlushD,FlushE}.
    function automatic logic [31:0] ctl();
        return {27'd0, StallF, StallD, StallE, FlushD, FlushE};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0; WA3E = 4'd0;
        RegWriteE = 1'b0; MemToRegE = 1'b0; BranchTakenE = 1'b0; MulStartE = 1'b0;
    endtask

    initial begin
        RD1E = 32'hAAAA0001; RD2E = 32'hBBBB0002;
        ALUResultM = 32'h0000_1234; ResultW = 32'h0000_5678;
        idle_inputs();
        rst = 1'b0;
        step();
        // Reset asserted with a write pending in E: tracking must stay cleared.
        WA3E = 4'd3; RegWriteE = 1'b1; RA1E = 4'd3; RA2E = 4'd3;
        step();
        #1;
        check("reset_fwdA", {30'd0, ForwardAE}, 32'd0);
        check("reset_fwdB", {30'd0, ForwardBE}, 32'd0);
        check("reset_srcA", SrcAE, 32'hAAAA0001);
        check("reset_srcB", SrcBE, 32'hBBBB0002);
        check("reset_ctl", ctl(), 32'd0);
        rst = 1'b1;
        idle_inputs();
        step();
        step();

        // M-stage forward
        WA3E = 4'd3; RegWriteE = 1'b1;
        step();
        WA3E = 4'd0; RegWriteE = 1'b0; RA1E = 4'd3;
        #1;
        check("mfwd_code", {30'd0, ForwardAE}, 32'd2);
        check("mfwd_src", SrcAE, 32'h0000_1234);
        check("mfwd_b_none", {30'd0, ForwardBE}, 32'd0);
        step();
        // Same producer now in W
        check("wfwd_code", {30'd0, ForwardAE}, 32'd1);
        check("wfwd_src", SrcAE, 32'h0000_5678);

        // Priority: M and W both write r5
        idle_inputs();
        WA3E = 4'd5; RegWriteE = 1'b1;
        step();
        step();
        WA3E = 4'd15; RegWriteE = 1'b1; RA2E = 4'd5;
        #1;
        check("prio_codeB", {30'd0, ForwardBE}, 32'd2);
        check("prio_srcB", SrcBE, 32'h0000_1234);
        step();
        // M writes r15, W writes r5
        RegWriteE = 1'b0; WA3E = 4'd0; RA1E = 4'd15;
        #1;
        check("r15_m_codeA", {30'd0, ForwardAE}, 32'd0);
        check("r15_m_srcA", SrcAE, 32'hAAAA0001);
        check("w5_codeB", {30'd0, ForwardBE}, 32'd1);
        check("w5_srcB", SrcBE, 32'h0000_5678);
        step();
        check("r15_w_codeA", {30'd0, ForwardAE}, 32'd0);

        // Load-use on RA2D
        idle_inputs();
        step();
        MemToRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd2; RA2D = 4'd2;
        #1;
        check("ldr_ctl", ctl(), 32'b11001);
        step();
        // Bubble in E after the flush; load now in M
        MemToRegE = 1'b0; RegWriteE = 1'b0; WA3E = 4'd0;
        #1;
        check("ldr_one_cycle", ctl(), 32'd0);
        step();
        RA2E = 4'd2;
        #1;
        check("ldr_dep_fwdB", {30'd0, ForwardBE}, 32'd1);
        check("ldr_dep_srcB", SrcBE, 32'h0000_5678);

        // Load-use on RA1D combined with a taken branch
        idle_inputs();
        MemToRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd6; RA1D = 4'd6; BranchTakenE = 1'b1;
        #1;
        check("ldr_branch_ctl", ctl(), 32'b00011);
        BranchTakenE = 1'b0;
        #1;
        check("ldr_ra1d_ctl", ctl(), 32'b11001);
        idle_inputs();
        BranchTakenE = 1'b1;
        #1;
        check("branch_ctl", ctl(), 32'b00011);
        idle_inputs();
        step();
        step();
        step();

`ifdef HAZARD_MUL_STALL_EN
        // Multiply: 3-cycle occupancy, second start ignored, branch ignored
        MulStartE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd7;
        #1;
        check("mul_c0_ctl", ctl(), 32'b11100);
        step();
        MulStartE = 1'b1; RA1E = 4'd7; BranchTakenE = 1'b1;
        #1;
        check("mul_c1_ctl", ctl(), 32'b11100);
        check("mul_bubble_fwdA", {30'd0, ForwardAE}, 32'd0);
        step();
        MulStartE = 1'b0; BranchTakenE = 1'b0;
        #1;
        check("mul_c2_ctl", ctl(), 32'b11100);
        check("mul_bubble_w_fwdA", {30'd0, ForwardAE}, 32'd0);
        step();
        check("mul_done_ctl", ctl(), 32'd0);
        idle_inputs();
        step();

        // Reset during the second busy cycle
        MulStartE = 1'b1;
        step();
        MulStartE = 1'b0;
        #1;
        check("mulrst_busy_ctl", ctl(), 32'b11100);
        rst = 1'b0;
        #1;
        check("mulrst_drop_ctl", ctl(), 32'd0);
        step();
        rst = 1'b1;
        step();
        check("mulrst_idle_ctl", ctl(), 32'd0);
`else
        MulStartE = 1'b1;
        #1;
        check("nomul_ctl", ctl(), 32'd0);
        step();
        check("nomul_ctl2", ctl(), 32'd0);
        idle_inputs();
        rst = 1'b0;
        #1;
        check("midrun_reset_ctl", ctl(), 32'd0);
        step();
        rst = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
